// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   DEPTH-entry FIFO of {instr, pc} pairs sitting between instruction memory
//   read data and decode. Fetch pushes with a valid/ready handshake, decode
//   pops with a valid/ready handshake, and a flush empties the queue on a
//   taken branch or jump. An entry pushed in one cycle is visible on rd_* the
//   next cycle; there is no same-cycle bypass in either direction.

module instr_fetch_queue #(
   parameter  int XLEN  = 32,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   // fetch side
   input  logic             wr_valid,
   input  logic [XLEN-1:0]  wr_instr,
   input  logic [XLEN-1:0]  wr_pc,
   output logic             wr_ready,
   // decode side
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [XLEN-1:0]  rd_instr,
   output logic [XLEN-1:0]  rd_pc,
   output logic [PTR_W:0]   count
);

   localparam int             CNT_W    = PTR_W + 1;
   localparam logic [PTR_W:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [PTR_W:0] ONE_CNT  = CNT_W'(1);
   localparam logic [PTR_W-1:0] ONE_PTR = PTR_W'(1);

   // Storage is split into two parallel arrays so each maps cleanly onto a
   // plain register file; they are always written together, so a pair can
   // never be split.
   logic [XLEN-1:0]  mem_instr [DEPTH];
   logic [XLEN-1:0]  mem_pc    [DEPTH];

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   cnt_q;

   logic             push;
   logic             pop;
   logic             clear;

   // Handshake status is derived purely from the occupancy count.
   always_comb begin
      wr_ready = (cnt_q != FULL_CNT);
      rd_valid = (cnt_q != '0);
   end

   // Accepted transfers; reset and flush both discard them.
   always_comb begin
      clear = reset | flush;
      push  = wr_valid & wr_ready & ~clear;
      pop   = rd_valid & rd_ready & ~clear;
   end

   // Head entry drives the outputs only while valid, so decode never sees X
   // from the unreset storage.
   always_comb begin
      // NOTE: every output gets a default before the conditional so no latch is inferred.
      rd_instr = '0;
      rd_pc    = '0;
      if (rd_valid) begin
         rd_instr = mem_instr[head];
         rd_pc    = mem_pc[head];
      end
   end

   assign count = cnt_q;

   // Write the incoming pair into the tail slot.
   // NOTE: the storage array is deliberately not reset; validity is tracked by
   // the pointers and count alone, and rd_* are masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         // NOTE: non-blocking assignments for all sequential state.
         mem_instr[tail] <= wr_instr;
         mem_pc[tail]    <= wr_pc;
      end
   end

   // Pointer and occupancy update; reset and flush return to empty.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            tail <= tail + ONE_PTR;
         end
         if (pop) begin
            head <= head + ONE_PTR;
         end
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + ONE_CNT;
            2'b01:   cnt_q <= cnt_q - ONE_CNT;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Directed bench for instr_fetch_queue (XLEN=32, DEPTH=4). Inputs change
//   1 time unit after the rising edge; outputs are checked at that same point,
//   well away from the next active edge.

module tb_instr_fetch_queue;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;
   localparam int PTR_W = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             reset;
   logic             flush;
   logic             wr_valid;
   logic [XLEN-1:0]  wr_instr;
   logic [XLEN-1:0]  wr_pc;
   logic             wr_ready;
   logic             rd_valid;
   logic             rd_ready;
   logic [XLEN-1:0]  rd_instr;
   logic [XLEN-1:0]  rd_pc;
   logic [PTR_W:0]   count;

   int n_vectors = 0;
   int n_miscompares = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .wr_valid (wr_valid),
      .wr_instr (wr_instr),
      .wr_pc    (wr_pc),
      .wr_ready (wr_ready),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .rd_instr (rd_instr),
      .rd_pc    (rd_pc),
      .count    (count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush    = 1'b0;
      wr_valid = 1'b0;
      wr_instr = '0;
      wr_pc    = '0;
      rd_ready = 1'b0;
   endtask

   task automatic push_one(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
      wr_valid = 1'b1;
      wr_instr = instr;
      wr_pc    = pc;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();

      // 1: reset state
      tick();
      tick();
      reset = 1'b0;
      check("rst_count",    64'(count),    64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_wr_ready", 64'(wr_ready), 64'd1);
      check("rst_rd_instr", 64'(rd_instr), 64'd0);
      check("rst_rd_pc",    64'(rd_pc),    64'd0);

      // 2: two pushes, then one pop
      push_one(32'h0050_0093, 32'h0);
      check("p1_count",     64'(count),    64'd1);
      check("p1_rd_instr",  64'(rd_instr), 64'h0050_0093);
      push_one(32'h00A0_0113, 32'h4);
      check("p2_count",     64'(count),    64'd2);
      check("p2_rd_instr",  64'(rd_instr), 64'h0050_0093);
      check("p2_rd_pc",     64'(rd_pc),    64'h0);
      pop_one();
      check("pop_rd_instr", 64'(rd_instr), 64'h00A0_0113);
      check("pop_rd_pc",    64'(rd_pc),    64'h4);
      check("pop_count",    64'(count),    64'd1);
      pop_one();
      check("drain_count",  64'(count),    64'd0);
      check("drain_rd_pc",  64'(rd_pc),    64'h0);

      // 3: fill to DEPTH, overflow attempt, pop with wr_valid held
      for (int i = 0; i < DEPTH; i++) begin
         push_one(32'hA000_0000 + 32'(i), 32'h100 + 32'(4 * i));
      end
      check("full_count",    64'(count),    64'd4);
      check("full_wr_ready", 64'(wr_ready), 64'd0);
      wr_valid = 1'b1;
      wr_instr = 32'hA000_0004;
      wr_pc    = 32'h110;
      tick();
      check("ovf_count",     64'(count),    64'd4);
      check("ovf_rd_pc",     64'(rd_pc),    64'h100);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      check("fpop_count",    64'(count),    64'd3);
      check("fpop_wr_ready", 64'(wr_ready), 64'd1);
      check("fpop_rd_pc",    64'(rd_pc),    64'h104);
      tick();
      wr_valid = 1'b0;
      check("refill_count",  64'(count),    64'd4);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("order_pc%0d", i),    64'(rd_pc),    64'(32'h104 + 32'(4 * i)));
         check($sformatf("order_instr%0d", i), 64'(rd_instr), 64'(32'hA000_0001 + 32'(i)));
         pop_one();
      end
      check("order_empty",   64'(rd_valid), 64'd0);

      // 4: steady push&pop across several pointer wraps
      push_one(32'h0000_0013, 32'h0);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         wr_valid = 1'b1;
         wr_instr = 32'h0000_0013;
         wr_pc    = 32'(4 * (i + 1));
         rd_ready = 1'b1;
         check($sformatf("steady_pc%0d", i), 64'(rd_pc), 64'(32'(4 * i)));
         tick();
         check($sformatf("steady_cnt%0d", i), 64'(count), 64'd1);
      end
      idle_inputs();
      check("steady_last_pc", 64'(rd_pc), 64'(32'(4 * 3 * DEPTH)));
      pop_one();
      check("steady_empty",  64'(count),    64'd0);

      // 5: flush with push and pop in the same cycle
      for (int i = 0; i < 3; i++) begin
         push_one(32'hB000_0000 + 32'(i), 32'h200 + 32'(4 * i));
      end
      check("pre_flush_count", 64'(count), 64'd3);
      flush    = 1'b1;
      wr_valid = 1'b1;
      wr_instr = 32'hB000_00FF;
      wr_pc    = 32'h2FC;
      rd_ready = 1'b1;
      tick();
      idle_inputs();
      check("flush_count",    64'(count),    64'd0);
      check("flush_rd_valid", 64'(rd_valid), 64'd0);
      check("flush_rd_pc",    64'(rd_pc),    64'h0);
      push_one(32'h0000_0013, 32'h40);
      check("post_flush_pc",    64'(rd_pc),    64'h40);
      check("post_flush_instr", 64'(rd_instr), 64'h0000_0013);
      check("post_flush_count", 64'(count),    64'd1);

      // 6: reset and flush together with a push pending
      push_one(32'h0000_0033, 32'h44);
      check("pre_rst_count", 64'(count), 64'd2);
      reset    = 1'b1;
      flush    = 1'b1;
      wr_valid = 1'b1;
      wr_instr = 32'hDEAD_BEEF;
      wr_pc    = 32'h80;
      tick();
      reset = 1'b0;
      idle_inputs();
      check("rf_count",    64'(count),    64'd0);
      check("rf_rd_valid", 64'(rd_valid), 64'd0);
      check("rf_wr_ready", 64'(wr_ready), 64'd1);
      tick();
      check("rf_not_stored", 64'(count),  64'd0);
      check("rf_rd_instr",   64'(rd_instr), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
